// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and a sizing helper.
package serial_adder_pkg;

    // Controller state. Encoding 2'd3 is unused and falls back to IDLE.
    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // The bit counter must be able to hold the value WIDTH itself, so a
    // power-of-two WIDTH needs one extra bit compared to $clog2(WIDTH).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Purely combinational 1-bit full-adder cell, the only arithmetic in the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Classic sum/majority equations for one bit position.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: pushes one bit per clock through a single full-adder cell
// and presents the WIDTH-bit sum plus carry with a start/busy/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_sr_next;
    logic             carry_r;
    logic [CNT_W-1:0] bit_cnt;
    logic             fa_s;
    logic             fa_cout;
    logic             accept;
    logic             last_bit;

    full_adder u_full_adder (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry_r),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // A new operation is taken from IDLE, or straight out of DONE for back-to-back use.
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Each new sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_narrow
            always_comb sum_sr_next = fa_s;
        end else begin : g_wide
            always_comb sum_sr_next = {fa_s, sum_sr[WIDTH-1:1]};
        end
    endgenerate

    // Control FSM: IDLE waits for start, RUN walks WIDTH bits, DONE lasts one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: state <= accept ? RUN : IDLE;
                RUN:        state <= last_bit ? DONE : RUN;
                default:    state <= IDLE;
            endcase
        end
    end

    // Operand shifters, carry and counter: loaded on accept, stepped once per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry_r <= 1'b0;
            bit_cnt <= '0;
        end else if (accept) begin
            a_sr    <= a;
            b_sr    <= b;
            sum_sr  <= '0;
            carry_r <= cin;
            bit_cnt <= '0;
        end else if (state == RUN) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            sum_sr  <= sum_sr_next;
            carry_r <= fa_cout;
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // Result registers change only on the edge that finishes the last bit, so they
    // keep showing the previous answer for the whole of RUN and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            carry_out <= 1'b0;
        end else if ((state == RUN) && last_bit) begin
            sum       <= sum_sr_next;
            carry_out <= fa_cout;
        end
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, multi-cycle adder with a start/busy/done handshake.
- Sits beside the combinational adders in the combinational/arithmetic set. Processes one bit per clock through a single 1-bit full-adder cell.
- Returns the same sum/carry_out result as the parallel adders for any WIDTH, trading latency for area.
- Used as the sequential counterpart in the arithmetic benchmark family.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an addition; sampled on rising clk edge.
- a  input  WIDTH  operand A; sampled only on the accepting start edge.
- b  input  WIDTH  operand B; sampled only on the accepting start edge.
- cin  input  1  carry-in; sampled only on the accepting start edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when sum/carry_out update.
- sum  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
- carry_out  output  1  registered result bit WIDTH of a+b+cin.

Behaviour:
- Interface: one clock domain (clk); rst is asynchronous and active-high.
- Reset:
  - State goes to IDLE immediately.
  - busy=0, done=0, sum=0, carry_out=0.
  - Operand shift registers, carry register and bit counter all clear to 0.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 latches a, b and cin, clears counter, moves to RUN. start=0 stays in IDLE.
  - RUN: each edge takes the LSBs of the A/B shift registers and the carry register through full_adder.
    - The sum bit shifts into the MSB of the sum shift register.
    - A and B shift right by one.
    - The carry register takes the full-adder carry out.
    - The counter increments.
    - After the edge that processes bit WIDTH-1 (counter reaching WIDTH), the state moves to DONE.
    - On that same edge the shift register loads into sum and the final carry loads into carry_out.
  - DONE: lasts exactly one cycle; done=1, busy=0.
    - Next edge: start=1 accepts a new operation (DONE->RUN, operands latched); otherwise DONE->IDLE.
- busy = (state==RUN). done = (state==DONE). Both are decoded from registered state.
- Latency:
  - start sampled at edge E0; bits 0..WIDTH-1 are processed on edges E1..EWIDTH.
  - done is high during the cycle following edge EWIDTH.
  - busy is high for exactly WIDTH cycles.
  - Back-to-back throughput is one result per WIDTH+1 cycles.
- Output stability: sum/carry_out hold the previous result throughout RUN and IDLE. They change only on the edge that enters DONE.
- start while RUN: ignored. Operands are not resampled and in-flight computation is unaffected.
- Input changes on a/b/cin outside an accepting edge have no effect.
- Width rule: full WIDTH+1-bit result; no truncation of carry. WIDTH=1 degenerates to one RUN cycle.
- Counter width is $clog2(WIDTH+1), so WIDTH that is a power of two does not wrap early.
- Reset mid-operation: RUN aborts asynchronously; no done pulse; outputs clear to 0. Next start after rst deassert behaves as from power-up.

Decomposition:
- Shared package serial_adder_pkg: state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2, plus the state typedef. Encoding 2'd3 is illegal and recovers to IDLE.
- Sub-module full_adder: purely combinational 1-bit cell (a, b, cin -> s, cout), instantiated once.
- Control FSM, shift registers and result registers live in serial_adder.

Test Plan:
1. Reset: rst=1 for 2 cycles, then start=0 -> busy=0, done=0, sum=0, carry_out=0; stays IDLE.
2. WIDTH=2, a=2'b11, b=2'b10, cin=0, start pulsed one cycle.
   - busy high for 2 cycles, then done pulse.
   - sum=2'b01, carry_out=1.
3. WIDTH=2, a=2'b11, b=2'b11, cin=1 -> sum=2'b11, carry_out=1; done exactly 2 cycles after the start edge.
4. WIDTH=8, a=8'hFF, b=8'h01, cin=0.
   - sum=8'h00, carry_out=1.
   - Change a/b and pulse start mid-RUN: ignored; result unchanged; single done pulse.
5. WIDTH=8, back-to-back: first op a=8'h12, b=8'h34 gives sum=8'h46, carry_out=0.
   - start held high during DONE with a=8'h80, b=8'h80 -> second op accepted with no IDLE cycle.
   - Second result sum=8'h00, carry_out=1.
   - Previous sum held until the second done.
6. WIDTH=8, assert rst asynchronously after bit 3 processed -> busy and done drop immediately; sum=0, carry_out=0; no done pulse; a fresh op afterwards computes correctly.
